uart_baud_ctrl: RTL and testbench
=================================

# uart_baud_ctrl

Sequencer and configuration controller for the UART baud rate generator. Starts and stops the generator's TX and RX clock enables per frame and counts the generator's ticks into bit boundaries: start, data and stop bits for TX, and mid-bit sample points for RX. Owns the generator's divisor register and accepts updates only while both directions are idle. Sits between the UART TX/RX shifters and the baud rate generator.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- STOP_BITS, 1, stop bits per frame (1..2)
- OVERSAMPLE, 16, RX ticks per bit; must be even
- DIV_W, 16, divisor width
- DEF_DIV, 16'd325, divisor value after reset
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- I_tx_req  in  1  level; request a TX frame
- O_tx_busy  out  1  TX frame in progress
- O_tx_bit_strobe  out  1  one-cycle pulse at each TX bit boundary
- O_tx_bit_idx  out  4  bit being started: 0 = start, 1..DATA_BITS = data, then stop bits
- O_tx_done  out  1  one-cycle pulse at frame end
- I_rx_start  in  1  one-cycle pulse on a synchronized falling edge of the RX line
- I_rx_line  in  1  synchronized RX line level
- O_rx_busy  out  1  RX frame in progress
- O_rx_sample  out  1  one-cycle mid-bit sample pulse
- O_rx_bit_idx  out  4  index of the bit being sampled (same encoding as TX)
- O_rx_done  out  1  one-cycle pulse at the last stop-bit sample
- O_rx_frame_err  out  1  pulses with O_rx_done when a stop bit samples low
- I_cfg_div  in  DIV_W  new divisor
- I_cfg_valid  in  1  divisor write request
- O_cfg_ready  out  1  divisor write accepted this cycle when valid
- O_baudrate_div  out  DIV_W  divisor driven to the generator
- O_baudrate_tx_clk_en  out  1  generator TX enable
- O_baudrate_rx_clk_en  out  1  generator RX enable
- I_baudrate_tx_clk  in  1  TX tick; one-cycle pulse, synchronous to clk
- I_baudrate_rx_clk  in  1  RX tick at OVERSAMPLE× baud; one-cycle pulse

## Operation
- TX FSM states: T_IDLE, T_WAIT, T_RUN.
  - T_IDLE: when I_tx_req=1 and no config write is accepted in the same cycle, set tx_en and go to T_WAIT.
  - T_WAIT: the first tick strobes idx 0 and moves to T_RUN.
  - T_RUN: each tick increments idx and strobes it, up to DATA_BITS+STOP_BITS.
  - The tick after the last stop bit pulses O_tx_done with no strobe.
  - At that final tick with I_tx_req=0: clear tx_en and return to T_IDLE.
  - At that final tick with I_tx_req=1 (back-to-back frame): tx_en stays high and the same tick also strobes idx 0 of the next frame.
- RX FSM states: R_IDLE, R_START, R_DATA.
  - R_IDLE: I_rx_start sets rx_en and moves to R_START. I_rx_start is ignored while O_rx_busy=1.
  - R_START: at RX tick OVERSAMPLE/2, check start-bit validity (see Configuration). A valid start zeroes the tick counter and moves to R_DATA.
  - R_DATA: every OVERSAMPLE ticks, pulse O_rx_sample with idx 1..DATA_BITS+STOP_BITS.
  - At any stop-bit sample with I_rx_line=0, latch an error. At the last sample, pulse O_rx_done and pulse O_rx_frame_err if the error latch is set. Clear rx_en and return to R_IDLE.
- Config:
  - O_cfg_ready = T_IDLE & R_IDLE & ~I_rx_start.
  - When I_cfg_valid & O_cfg_ready, O_baudrate_div ← I_cfg_div on the next clk.
  - When a config write and I_tx_req occur in the same cycle, the config write wins and TX starts one cycle later.
- TX and RX are fully independent and may run at the same time.
- The RX tick counter is $clog2(OVERSAMPLE) bits wide and wraps to 0 at OVERSAMPLE-1.

## Timing
- Reset values:
  - All outputs are 0 except O_baudrate_div = DEF_DIV.
  - FSMs are in T_IDLE and R_IDLE; counters are 0.
  - Reset mid-frame aborts immediately, with no done pulse.
- Clock enables: O_baudrate_*_clk_en rise one clk after the triggering request. They fall one clk after the done pulse, except in the back-to-back TX case.
- Strobes: O_tx_bit_strobe, O_rx_sample, the done pulses and the idx outputs are registered. They appear one clk after the causing tick, and idx is valid in the same cycle as its strobe.
- Busy flags: O_tx_busy and O_rx_busy equal "FSM not idle", registered.
- Ticks while the corresponding enable is low are ignored.

## Configuration
- Macro: UART_BAUD_CTRL_FALSE_START_EN.
- With the macro defined: at the R_START check, I_rx_line=1 is a false start. Clear rx_en, return to R_IDLE, and generate no sample or done pulse.
- With the macro undefined: the start bit is never checked. R_START always proceeds to R_DATA at tick OVERSAMPLE/2.

## Test plan
- TX single frame, DATA_BITS=8, STOP_BITS=1, I_tx_req pulsed for one cycle -> ten strobes with idx 0..9, then O_tx_done on the 11th tick; tx_en low one clk later.
- TX back-to-back, I_tx_req held high -> tx_en never drops; the 11th tick gives O_tx_done together with a strobe at idx 0.
- RX valid frame, 0x55 driven, stop bit high -> nine samples, each at tick 8+16k after I_rx_start, with idx 1..9; O_rx_done=1, O_rx_frame_err=0.
- RX stop bit low -> O_rx_frame_err=1 together with O_rx_done. With the macro defined, a glitch that returns high before tick 8 -> no samples, and O_rx_busy drops.
- Config write of 16'd54 while TX is busy -> O_cfg_ready=0 and the divisor is unchanged; after O_tx_done, the write is accepted and O_baudrate_div=54 on the next clk.
- Assert rst mid-RX frame -> all outputs go to their reset values asynchronously, with no done pulse; the next I_rx_start is accepted normally.

Source files
------------

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: frame sequencer and divisor owner for the UART baud rate generator.
// Define UART_BAUD_CTRL_FALSE_START_EN to abort RX frames whose start bit samples high.
module uart_baud_ctrl #(
  parameter int               DATA_BITS  = 8,
  parameter int               STOP_BITS  = 1,
  parameter int               OVERSAMPLE = 16,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DEF_DIV    = 16'd325
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_tx_req,
  output logic             O_tx_busy,
  output logic             O_tx_bit_strobe,
  output logic [3:0]       O_tx_bit_idx,
  output logic             O_tx_done,
  input  logic             I_rx_start,
  input  logic             I_rx_line,
  output logic             O_rx_busy,
  output logic             O_rx_sample,
  output logic [3:0]       O_rx_bit_idx,
  output logic             O_rx_done,
  output logic             O_rx_frame_err,
  input  logic [DIV_W-1:0] I_cfg_div,
  input  logic             I_cfg_valid,
  output logic             O_cfg_ready,
  output logic [DIV_W-1:0] O_baudrate_div,
  output logic             O_baudrate_tx_clk_en,
  output logic             O_baudrate_rx_clk_en,
  input  logic             I_baudrate_tx_clk,
  input  logic             I_baudrate_rx_clk
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [3:0]       LAST_IDX = 4'(DATA_BITS + STOP_BITS);
  localparam logic [3:0]       DATA_IDX = 4'(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_WAIT  = 2'd1;
  localparam logic [1:0] T_RUN   = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  logic [1:0]       tx_state;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_err;
  logic             cfg_accept;
  logic             tx_start;
  logic             tx_tick;
  logic             rx_accept;
  logic             rx_tick;
  logic [3:0]       rx_bit_nxt;
  logic             rx_stop_low;

  // Held low during reset so every output reads 0 while rst is asserted.
  assign O_cfg_ready = ~rst & (tx_state == T_IDLE) & (rx_state == R_IDLE) & ~I_rx_start;
  assign cfg_accept  = I_cfg_valid & O_cfg_ready;
  assign tx_start    = (tx_state == T_IDLE) & I_tx_req & ~cfg_accept;
  assign tx_tick     = I_baudrate_tx_clk & O_baudrate_tx_clk_en;
  assign rx_accept   = (rx_state == R_IDLE) & I_rx_start;
  assign rx_tick     = I_baudrate_rx_clk & O_baudrate_rx_clk_en;
  assign rx_bit_nxt  = O_rx_bit_idx + 4'd1;
  assign rx_stop_low = (rx_bit_nxt > DATA_IDX) & ~I_rx_line;
  assign O_tx_busy   = (tx_state != T_IDLE);
  assign O_rx_busy   = (rx_state != R_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O_baudrate_div <= DEF_DIV;
    end else if (cfg_accept) begin
      O_baudrate_div <= I_cfg_div;
    end
  end

  // In idle the enable follows the start request, so it falls the cycle after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state             <= T_IDLE;
      O_baudrate_tx_clk_en <= 1'b0;
      O_tx_bit_strobe      <= 1'b0;
      O_tx_bit_idx         <= 4'd0;
      O_tx_done            <= 1'b0;
    end else begin
      O_tx_bit_strobe <= 1'b0;
      O_tx_done       <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          O_baudrate_tx_clk_en <= tx_start;
          if (tx_start) tx_state <= T_WAIT;
        end
        T_WAIT: begin
          if (tx_tick) begin
            O_tx_bit_strobe <= 1'b1;
            O_tx_bit_idx    <= 4'd0;
            tx_state        <= T_RUN;
          end
        end
        T_RUN: begin
          if (tx_tick) begin
            if (O_tx_bit_idx == LAST_IDX) begin
              O_tx_done <= 1'b1;
              if (I_tx_req) begin
                O_tx_bit_strobe <= 1'b1;
                O_tx_bit_idx    <= 4'd0;
              end else begin
                tx_state <= T_IDLE;
              end
            end else begin
              O_tx_bit_strobe <= 1'b1;
              O_tx_bit_idx    <= O_tx_bit_idx + 4'd1;
            end
          end
        end
        default: begin
          tx_state             <= T_IDLE;
          O_baudrate_tx_clk_en <= 1'b0;
        end
      endcase
    end
  end

  // O_rx_bit_idx doubles as the bit counter: it holds the index of the last sample taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state             <= R_IDLE;
      O_baudrate_rx_clk_en <= 1'b0;
      rx_cnt               <= '0;
      rx_err               <= 1'b0;
      O_rx_sample          <= 1'b0;
      O_rx_bit_idx         <= 4'd0;
      O_rx_done            <= 1'b0;
      O_rx_frame_err       <= 1'b0;
    end else begin
      O_rx_sample    <= 1'b0;
      O_rx_done      <= 1'b0;
      O_rx_frame_err <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          O_baudrate_rx_clk_en <= rx_accept;
          if (rx_accept) begin
            rx_state     <= R_START;
            rx_cnt       <= '0;
            rx_err       <= 1'b0;
            O_rx_bit_idx <= 4'd0;
          end
        end
        R_START: begin
          if (rx_tick) begin
            if (rx_cnt == HALF_CNT) begin
`ifdef UART_BAUD_CTRL_FALSE_START_EN
              if (I_rx_line) begin
                rx_state             <= R_IDLE;
                O_baudrate_rx_clk_en <= 1'b0;
              end else begin
                rx_state <= R_DATA;
                rx_cnt   <= '0;
              end
`else
              rx_state <= R_DATA;
              rx_cnt   <= '0;
`endif
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        R_DATA: begin
          if (rx_tick) begin
            if (rx_cnt == FULL_CNT) begin
              rx_cnt       <= '0;
              O_rx_sample  <= 1'b1;
              O_rx_bit_idx <= rx_bit_nxt;
              if (rx_stop_low) rx_err <= 1'b1;
              if (rx_bit_nxt == LAST_IDX) begin
                O_rx_done      <= 1'b1;
                O_rx_frame_err <= rx_err | rx_stop_low;
                rx_state       <= R_IDLE;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        default: begin
          rx_state             <= R_IDLE;
          O_baudrate_rx_clk_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Randomized self-checking bench for uart_baud_ctrl; the bench plays the baud generator,
// emitting random ticks only while the matching enable is high.
module tb_uart_baud_ctrl;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int OS        = 16;
  localparam int DIV_W     = 16;
  localparam int LASTI     = DATA_BITS + STOP_BITS;
  localparam int FLEN      = LASTI + 1;
  localparam int HALF      = OS / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             I_tx_req = 1'b0;
  logic             O_tx_busy, O_tx_bit_strobe, O_tx_done;
  logic [3:0]       O_tx_bit_idx;
  logic             I_rx_start = 1'b0;
  logic             I_rx_line = 1'b1;
  logic             O_rx_busy, O_rx_sample, O_rx_done, O_rx_frame_err;
  logic [3:0]       O_rx_bit_idx;
  logic [DIV_W-1:0] I_cfg_div = '0;
  logic             I_cfg_valid = 1'b0;
  logic             O_cfg_ready;
  logic [DIV_W-1:0] O_baudrate_div;
  logic             O_baudrate_tx_clk_en, O_baudrate_rx_clk_en;
  logic             I_baudrate_tx_clk = 1'b0;
  logic             I_baudrate_rx_clk = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_baud_ctrl #(
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .OVERSAMPLE(OS),
    .DIV_W     (DIV_W),
    .DEF_DIV   (16'd325)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .I_tx_req            (I_tx_req),
    .O_tx_busy           (O_tx_busy),
    .O_tx_bit_strobe     (O_tx_bit_strobe),
    .O_tx_bit_idx        (O_tx_bit_idx),
    .O_tx_done           (O_tx_done),
    .I_rx_start          (I_rx_start),
    .I_rx_line           (I_rx_line),
    .O_rx_busy           (O_rx_busy),
    .O_rx_sample         (O_rx_sample),
    .O_rx_bit_idx        (O_rx_bit_idx),
    .O_rx_done           (O_rx_done),
    .O_rx_frame_err      (O_rx_frame_err),
    .I_cfg_div           (I_cfg_div),
    .I_cfg_valid         (I_cfg_valid),
    .O_cfg_ready         (O_cfg_ready),
    .O_baudrate_div      (O_baudrate_div),
    .O_baudrate_tx_clk_en(O_baudrate_tx_clk_en),
    .O_baudrate_rx_clk_en(O_baudrate_rx_clk_en),
    .I_baudrate_tx_clk   (I_baudrate_tx_clk),
    .I_baudrate_rx_clk   (I_baudrate_rx_clk)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] outs();
    return {O_tx_busy, O_tx_bit_strobe, O_tx_bit_idx, O_tx_done,
            O_rx_busy, O_rx_sample, O_rx_bit_idx, O_rx_done, O_rx_frame_err,
            O_cfg_ready, O_baudrate_tx_clk_en, O_baudrate_rx_clk_en};
  endfunction

  // Line-level frame: bit 0 = start, bits 1..DATA_BITS = data LSB first, then stop bits.
  function automatic logic [15:0] make_frame(input logic [8:0] data, input logic start,
                                             input logic stop);
    logic [15:0] fv = '0;
    fv[0] = start;
    for (int k = 1; k <= DATA_BITS; k++) fv[k] = data[k-1];
    for (int k = DATA_BITS + 1; k <= LASTI; k++) fv[k] = stop;
    return fv;
  endfunction

  // Line level during RX tick m (1-based): start bit up to the midpoint, then bit k.
  function automatic logic line_at(input logic [15:0] fv, input int m);
    if (m <= HALF) return fv[0];
    return fv[(m - HALF + OS - 1) / OS];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (outs() !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", outs());
    end
    total++;
    if (O_baudrate_div !== 16'd325) begin
      bad++;
      $display("FAIL reset_div: got %0d want 325", O_baudrate_div);
    end
    rst = 1'b0;
    #1;
    total++;
    if (O_cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cfg_ready: got %b want 1", O_cfg_ready);
    end
    step();
  endtask

  // frames == 1: one-cycle request; frames > 1: request held for back-to-back frames.
  task automatic test_tx(input int frames, input string name);
    int         n      = 0;
    int         last_n = frames * FLEN + 1;
    bit         tick;
    bit         fin    = 1'b0;
    bit         e_str  = 1'b0;
    bit         e_done = 1'b0;
    logic [3:0] e_idx  = 4'd0;
    I_tx_req = 1'b1;
    step();
    if (frames == 1) I_tx_req = 1'b0;
    total++;
    if ({O_baudrate_tx_clk_en, O_tx_busy} !== 2'b11) begin
      bad++;
      $display("FAIL %s_start: en/busy got %b want 11", name, {O_baudrate_tx_clk_en, O_tx_busy});
    end
    for (int c = 0; c < 3000 && !fin; c++) begin
      I_baudrate_tx_clk = 1'b0;
      total++;
      if ({O_tx_bit_strobe, O_tx_done} !== {e_str, e_done}) begin
        bad++;
        $display("FAIL %s_pulse tick %0d: strobe/done got %b want %b", name, n,
                 {O_tx_bit_strobe, O_tx_done}, {e_str, e_done});
      end
      if (e_str) begin
        total++;
        if (O_tx_bit_idx !== e_idx) begin
          bad++;
          $display("FAIL %s_idx tick %0d: got %0d want %0d", name, n, O_tx_bit_idx, e_idx);
        end
      end
      if (e_done && n == last_n) begin
        fin = 1'b1;
      end else begin
        if (frames > 1) begin
          total++;
          if (O_baudrate_tx_clk_en !== 1'b1) begin
            bad++;
            $display("FAIL %s_en_held tick %0d: got 0 want 1", name, n);
          end
        end
        if (n == last_n - 1) I_tx_req = 1'b0;
        tick = O_baudrate_tx_clk_en && ($urandom_range(0, 2) == 0);
        if (tick) n++;
        e_done = tick && n > FLEN && ((n - 1) % FLEN) == 0;
        e_str  = tick && !(e_done && !I_tx_req);
        e_idx  = 4'((n - 1) % FLEN);
        I_baudrate_tx_clk = tick;
        step();
      end
    end
    if (!fin) begin
      bad++;
      total++;
      $display("FAIL %s_timeout: got %0d ticks want %0d", name, n, last_n);
    end else begin
      total++;
      if ({O_baudrate_tx_clk_en, O_tx_busy} !== 2'b10) begin
        bad++;
        $display("FAIL %s_end: en/busy got %b want 10", name, {O_baudrate_tx_clk_en, O_tx_busy});
      end
      step();
      total++;
      if (O_baudrate_tx_clk_en !== 1'b0) begin
        bad++;
        $display("FAIL %s_en_fall: got %b want 0", name, O_baudrate_tx_clk_en);
      end
    end
  endtask

  task automatic test_rx(input logic [15:0] fv, input string name);
    int         m      = 0;
    bit         tick;
    bit         fin    = 1'b0;
    bit         e_s    = 1'b0;
    bit         e_d    = 1'b0;
    bit         e_f    = 1'b0;
    bit         e_ab   = 1'b0;
    bit         ferr_exp = 1'b0;
    bit         abort_exp;
    logic [3:0] e_i    = 4'd0;
    for (int k = DATA_BITS + 1; k <= LASTI; k++) if (!fv[k]) ferr_exp = 1'b1;
`ifdef UART_BAUD_CTRL_FALSE_START_EN
    abort_exp = fv[0];
`else
    abort_exp = 1'b0;
`endif
    I_rx_line  = 1'b0;
    I_rx_start = 1'b1;
    #1;
    total++;
    if (O_cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_on_start: got %b want 0", name, O_cfg_ready);
    end
    step();
    I_rx_start = 1'b0;
    I_rx_line  = fv[0];
    total++;
    if ({O_baudrate_rx_clk_en, O_rx_busy} !== 2'b11) begin
      bad++;
      $display("FAIL %s_start: en/busy got %b want 11", name, {O_baudrate_rx_clk_en, O_rx_busy});
    end
    for (int c = 0; c < 6000 && !fin; c++) begin
      I_baudrate_rx_clk = 1'b0;
      I_rx_start        = 1'b0;
      total++;
      if ({O_rx_sample, O_rx_done, O_rx_frame_err} !== {e_s, e_d, e_f}) begin
        bad++;
        $display("FAIL %s_pulse tick %0d: sample/done/ferr got %b want %b", name, m,
                 {O_rx_sample, O_rx_done, O_rx_frame_err}, {e_s, e_d, e_f});
      end
      if (e_s) begin
        total++;
        if (O_rx_bit_idx !== e_i) begin
          bad++;
          $display("FAIL %s_idx tick %0d: got %0d want %0d", name, m, O_rx_bit_idx, e_i);
        end
      end
      if (e_d) begin
        fin = 1'b1;
      end else if (e_ab) begin
        total++;
        if ({O_baudrate_rx_clk_en, O_rx_busy} !== 2'b00) begin
          bad++;
          $display("FAIL %s_false_start: en/busy got %b want 00", name,
                   {O_baudrate_rx_clk_en, O_rx_busy});
        end
        fin = 1'b1;
      end else begin
        // Stray start pulses mid-frame must be ignored.
        I_rx_start = (m > 0) && ($urandom_range(0, 15) == 0);
        tick = O_baudrate_rx_clk_en && ($urandom_range(0, 1) == 1);
        if (tick) begin
          m++;
          I_rx_line = line_at(fv, m);
        end
        e_ab = tick && m == HALF && abort_exp;
        e_s  = tick && !abort_exp && m > HALF && ((m - HALF) % OS) == 0;
        e_i  = 4'((m - HALF) / OS);
        e_d  = e_s && ((m - HALF) / OS) == LASTI;
        e_f  = e_d && ferr_exp;
        I_baudrate_rx_clk = tick;
        step();
      end
    end
    I_rx_start = 1'b0;
    if (!fin) begin
      bad++;
      total++;
      $display("FAIL %s_timeout: got %0d ticks", name, m);
    end else if (abort_exp) begin
      for (int c = 0; c < 20; c++) step();
      total++;
      if ({O_rx_busy, O_baudrate_rx_clk_en} !== 2'b00) begin
        bad++;
        $display("FAIL %s_after_abort: busy/en got %b want 00", name,
                 {O_rx_busy, O_baudrate_rx_clk_en});
      end
    end else begin
      total++;
      if ({O_baudrate_rx_clk_en, O_rx_busy} !== 2'b10) begin
        bad++;
        $display("FAIL %s_end: en/busy got %b want 10", name, {O_baudrate_rx_clk_en, O_rx_busy});
      end
      step();
      total++;
      if (O_baudrate_rx_clk_en !== 1'b0) begin
        bad++;
        $display("FAIL %s_en_fall: got %b want 0", name, O_baudrate_rx_clk_en);
      end
    end
    I_rx_line = 1'b1;
    step();
  endtask

  // Ticks TX until done while checking the divisor never moves.
  task automatic drain_tx(input logic [15:0] hold_div, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      I_baudrate_tx_clk = 1'b0;
      total++;
      if (O_baudrate_div !== hold_div) begin
        bad++;
        $display("FAIL %s_div_hold: got %0d want %0d", name, O_baudrate_div, hold_div);
      end
      if (O_tx_done === 1'b1) seen = 1'b1;
      else begin
        I_baudrate_tx_clk = O_baudrate_tx_clk_en && ($urandom_range(0, 1) == 1);
        step();
      end
    end
    if (!seen) begin
      bad++;
      total++;
      $display("FAIL %s_timeout: got no done want done", name);
    end
  endtask

  task automatic test_cfg();
    I_cfg_div = 16'd54;
    I_tx_req  = 1'b1;
    step();
    I_tx_req    = 1'b0;
    I_cfg_valid = 1'b1;
    #1;
    total++;
    if (O_cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL cfg_ready_busy: got %b want 0", O_cfg_ready);
    end
    drain_tx(16'd325, "cfg_busy");
    total++;
    if (O_cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_ready_idle: got %b want 1", O_cfg_ready);
    end
    step();
    I_cfg_valid = 1'b0;
    total++;
    if (O_baudrate_div !== 16'd54) begin
      bad++;
      $display("FAIL cfg_write: got %0d want 54", O_baudrate_div);
    end
    step();
    // Config write and TX request together: the write lands, TX starts a cycle later.
    I_cfg_div   = 16'd100;
    I_cfg_valid = 1'b1;
    I_tx_req    = 1'b1;
    step();
    I_cfg_valid = 1'b0;
    total++;
    if ({O_baudrate_div, O_tx_busy} !== {16'd100, 1'b0}) begin
      bad++;
      $display("FAIL cfg_collide: div/busy got %0d/%b want 100/0", O_baudrate_div, O_tx_busy);
    end
    step();
    I_tx_req = 1'b0;
    total++;
    if (O_tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL cfg_collide_tx_late: busy got %b want 1", O_tx_busy);
    end
    drain_tx(16'd100, "cfg_collide");
    step();
    step();
  endtask

  task automatic test_reset_mid_rx();
    int dones = 0;
    I_rx_line  = 1'b0;
    I_rx_start = 1'b1;
    step();
    I_rx_start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      I_baudrate_rx_clk = O_baudrate_rx_clk_en && ($urandom_range(0, 1) == 1);
      step();
      if (O_rx_done === 1'b1) dones++;
    end
    I_baudrate_rx_clk = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 18'd0) begin
      bad++;
      $display("FAIL reset_mid_rx_outputs: got %b want 0", outs());
    end
    total++;
    if (O_baudrate_div !== 16'd325) begin
      bad++;
      $display("FAIL reset_mid_rx_div: got %0d want 325", O_baudrate_div);
    end
    step();
    if (O_rx_done === 1'b1) dones++;
    rst       = 1'b0;
    I_rx_line = 1'b1;
    step();
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_rx_done: got %0d done pulses want 0", dones);
    end
    test_rx(make_frame(9'($urandom), 1'b0, 1'b1), "rx_after_reset");
  endtask

  initial begin
    #1;
    test_reset();
    test_tx(1, "tx_single");
    test_tx(3, "tx_b2b");
    test_rx(make_frame(9'h055, 1'b0, 1'b1), "rx_55");
    test_rx(make_frame(9'h0A3, 1'b0, 1'b0), "rx_stop_low");
    for (int i = 0; i < 3; i++)
      test_rx(make_frame(9'($urandom), 1'b0, 1'($urandom_range(0, 1))), "rx_rand");
    test_rx(make_frame(9'h0C6, 1'b1, 1'b1), "rx_glitch");
    test_cfg();
    test_reset_mid_rx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
